// File: rtl/mode_pkg.sv
// rtl/mode_pkg.sv - shared mode encodings, button indices and request priority helper
package mode_pkg;

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    PLAY = 2'd1,
    RAW  = 2'd2
  } sysmode_t;

  localparam int BTN_EDIT = 0;
  localparam int BTN_PLAY = 1;
  localparam int BTN_RAW  = 2;
  localparam int NUM_BTNS = 3;

  // EDIT beats PLAY beats RAW; losers are dropped, so the result is one-hot or zero.
  function automatic logic [NUM_BTNS-1:0] pick_request(input logic [NUM_BTNS-1:0] rise);
    logic [NUM_BTNS-1:0] req;
    req = '0;
    if (rise[BTN_EDIT])      req[BTN_EDIT] = 1'b1;
    else if (rise[BTN_PLAY]) req[BTN_PLAY] = 1'b1;
    else if (rise[BTN_RAW])  req[BTN_RAW]  = 1'b1;
    return req;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser, stability counter, debounced level and rise flag
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   sync_s;
  logic                   differ;
  logic                   at_max;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    differ = (sync_s != level_q);
    at_max = (cnt_q == CNT_MAX);
    // Flags the edge at which the level will go 0->1, so the top can register the pulse
    // on that same edge.
    rise   = differ & at_max & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      if (!differ) begin
        cnt_q <= '0;
      end else if (at_max) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/mode_button_conditioner.sv
// rtl/mode_button_conditioner.sv - three debounced buttons into prioritised one-cycle mode requests
module mode_button_conditioner
  import mode_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_edit_raw,
  input  logic                btn_play_raw,
  input  logic                btn_raw_raw,
  output logic                set_edit,
  output logic                set_play,
  output logic                set_raw,
  output logic [NUM_BTNS-1:0] btn_state
);

  logic [NUM_BTNS-1:0] raw_in;
  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] rise;
  logic [NUM_BTNS-1:0] req_d;
  logic [NUM_BTNS-1:0] req_q;

  assign raw_in[BTN_EDIT] = btn_edit_raw;
  assign raw_in[BTN_PLAY] = btn_play_raw;
  assign raw_in[BTN_RAW]  = btn_raw_raw;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(raw_in[i]),
      .level  (level[i]),
      .rise   (rise[i])
    );
  end

  always_comb begin
    req_d = pick_request(rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign set_edit  = req_q[BTN_EDIT];
  assign set_play  = req_q[BTN_PLAY];
  assign set_raw   = req_q[BTN_RAW];
  assign btn_state = level;

endmodule

// File: tb/tb_mode_button_conditioner.sv
// tb/tb_mode_button_conditioner.sv - directed self-checking bench for mode_button_conditioner
module tb_mode_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic       btn_edit_raw;
  logic       btn_play_raw;
  logic       btn_raw_raw;
  logic       set_edit;
  logic       set_play;
  logic       set_raw;
  logic [2:0] btn_state;

  int n_cmp;
  int n_bad;

  mode_button_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_edit_raw(btn_edit_raw),
    .btn_play_raw(btn_play_raw),
    .btn_raw_raw (btn_raw_raw),
    .set_edit    (set_edit),
    .set_play    (set_play),
    .set_raw     (set_raw),
    .btn_state   (btn_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [2:0] exp_state, input logic [2:0] exp_set);
    logic [2:0] obs_set;
    obs_set = {set_raw, set_play, set_edit};
    n_cmp++;
    assert (btn_state === exp_state) else begin
      n_bad++;
      $error("FAIL %s btn_state observed=%b expected=%b", tag, btn_state, exp_state);
    end
    n_cmp++;
    assert (obs_set === exp_set) else begin
      n_bad++;
      $error("FAIL %s set{raw,play,edit} observed=%b expected=%b", tag, obs_set, exp_set);
    end
  endtask

  // Advance one active edge, sample 1 time unit later, and check the one-hot-or-zero rule.
  task automatic tick();
    logic [2:0] s;
    @(posedge clk);
    #1;
    s = {set_raw, set_play, set_edit};
    n_cmp++;
    assert ((s & (s - 3'd1)) == 3'd0) else begin
      n_bad++;
      $error("FAIL onehot0 set{raw,play,edit} observed=%b expected=one-hot-or-zero", s);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    btn_edit_raw = 1'b0;
    btn_play_raw = 1'b0;
    btn_raw_raw  = 1'b0;

    // 1: reset held while buttons toggle
    for (int i = 0; i < 8; i++) begin
      btn_edit_raw = i[0];
      btn_play_raw = i[1];
      btn_raw_raw  = ~i[0];
      tick();
      check("reset_hold", 3'b000, 3'b000);
    end
    btn_edit_raw = 1'b0;
    btn_play_raw = 1'b0;
    btn_raw_raw  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle", 3'b000, 3'b000);
    end

    // 2: clean PLAY press and release
    btn_play_raw = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("play_wait", 3'b000, 3'b000);
    end
    tick();
    check("play_edge6", 3'b010, 3'b010);
    tick();
    check("play_edge7", 3'b010, 3'b000);
    btn_play_raw = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("play_rel_wait", 3'b010, 3'b000);
    end
    tick();
    check("play_rel_edge6", 3'b000, 3'b000);

    // 3: bouncing EDIT never qualifies
    btn_edit_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); check("bounce_hi1", 3'b000, 3'b000); end
    btn_edit_raw = 1'b0;
    tick();
    check("bounce_lo", 3'b000, 3'b000);
    btn_edit_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); check("bounce_hi2", 3'b000, 3'b000); end
    btn_edit_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); check("bounce_tail", 3'b000, 3'b000); end

    // 4: simultaneous press, EDIT wins
    btn_edit_raw = 1'b1;
    btn_play_raw = 1'b1;
    btn_raw_raw  = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("simul_wait", 3'b000, 3'b000);
    end
    tick();
    check("simul_edge6", 3'b111, 3'b001);
    tick();
    check("simul_edge7", 3'b111, 3'b000);

    // 1b: asynchronous reset between edges clears outputs immediately
    #3;
    btn_edit_raw = 1'b0;
    btn_play_raw = 1'b0;
    btn_raw_raw  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset", 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) begin tick(); check("async_hold", 3'b000, 3'b000); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); check("async_after", 3'b000, 3'b000); end

    // 5: EDIT held, RAW pressed 10 cycles later
    btn_edit_raw = 1'b1;
    for (int e = 1; e <= 5; e++) begin tick(); check("ovl_edit_wait", 3'b000, 3'b000); end
    tick();
    check("ovl_edit_edge6", 3'b001, 3'b001);
    for (int e = 7; e <= 10; e++) begin tick(); check("ovl_edit_hold", 3'b001, 3'b000); end
    btn_raw_raw = 1'b1;
    for (int e = 1; e <= 5; e++) begin tick(); check("ovl_raw_wait", 3'b001, 3'b000); end
    tick();
    check("ovl_raw_edge6", 3'b101, 3'b100);
    tick();
    check("ovl_raw_edge7", 3'b101, 3'b000);
    btn_edit_raw = 1'b0;
    btn_raw_raw  = 1'b0;
    for (int e = 1; e <= 5; e++) begin tick(); check("ovl_rel_wait", 3'b101, 3'b000); end
    tick();
    check("ovl_rel_edge6", 3'b000, 3'b000);

    // 6: reset mid-debounce with PLAY held across reset release
    btn_play_raw = 1'b1;
    for (int e = 1; e <= 3; e++) begin tick(); check("mid_wait", 3'b000, 3'b000); end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) begin tick(); check("mid_hold", 3'b000, 3'b000); end
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin tick(); check("held_wait", 3'b000, 3'b000); end
    tick();
    check("held_edge6", 3'b010, 3'b010);
    tick();
    check("held_edge7", 3'b010, 3'b000);
    btn_play_raw = 1'b0;
    for (int e = 1; e <= 5; e++) begin tick(); check("held_rel_wait", 3'b010, 3'b000); end
    tick();
    check("held_rel_edge6", 3'b000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
